// File: rtl/breakout_pkg.sv
// Shared types and constants for the Breakout score display path.
// Holds the BCD digit type, the converter FSM state type and a parameter sizing helper.
package breakout_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    // Number of decimal digits needed to show the largest value of a bits-wide unsigned number.
    function automatic int dec_digits_for_bits(input int bits);
        logic [63:0] v;
        int n;
        v = (64'd1 << bits) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next left shift.
module bcd_digit_adjust
    import breakout_pkg::*;
(
    input  bcd_t din,
    output bcd_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter feeding SevenSegmentControl; one bit per clock.
// Define SCORE_BLANK_EN to blank leading zero digits through turn_on.
module score_bcd_converter
    import breakout_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = NUM_DIGITS
) (
    input  logic                   clock,
    input  logic                   reset_L,
    input  logic                   start,
    input  logic [BIN_W-1:0]       bin_in,
    output logic                   ready,
    output logic                   done,
    output logic [DIGITS-1:0][3:0] bcd,
    output logic [DIGITS-1:0]      turn_on,
    output conv_state_t            dbg_state
);

    // Handshake: a conversion is accepted on a posedge where start && ready; ready is high
    // only in IDLE, starts seen at other times are dropped, and done pulses for exactly one
    // cycle in the same cycle that bcd/turn_on take their new values.

    localparam int CW = $clog2(BIN_W + 1);

    if (dec_digits_for_bits(BIN_W) > DIGITS) begin : g_param_check
        $error("score_bcd_converter: BIN_W=%0d does not fit in %0d BCD digits", BIN_W, DIGITS);
    end

    conv_state_t              state;
    logic [DIGITS-1:0][3:0]   scratch;
    logic [DIGITS-1:0][3:0]   adjusted;
    logic [BIN_W-1:0]         shreg;
    logic [CW-1:0]            count;
    logic [DIGITS-1:0]        mask;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (scratch[g]),
            .dout (adjusted[g])
        );
    end

`ifdef SCORE_BLANK_EN
    localparam logic [DIGITS-1:0] ON_RESET = DIGITS'(1);

    // Light every digit at or below the most significant nonzero one; digit 0 always lit.
    always_comb begin
        logic seen;
        seen = 1'b0;
        mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (scratch[i] != 4'd0);
            mask[i] = seen;
        end
        mask[0] = 1'b1;
    end
`else
    localparam logic [DIGITS-1:0] ON_RESET = '1;

    assign mask = '1;
`endif

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            bcd     <= '0;
            turn_on <= ON_RESET;
            scratch <= '0;
            shreg   <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        count   <= CW'(BIN_W);
                        ready   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        {scratch, shreg} <= {adjusted, shreg} << 1;
                        count            <= count - CW'(1);
                    end else begin
                        bcd     <= scratch;
                        turn_on <= mask;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter (BIN_W=16, DIGITS=8), directed plus random scores.
module tb_score_bcd_converter;
    import breakout_pkg::*;

    logic            clock;
    logic            reset_L;
    logic            start;
    logic [15:0]     bin_in;
    logic            ready;
    logic            done;
    logic [7:0][3:0] bcd;
    logic [7:0]      turn_on;
    conv_state_t     dbg_state;

    int n_checks;
    int n_errors;

    score_bcd_converter #(.BIN_W(16), .DIGITS(8)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .start     (start),
        .bin_in    (bin_in),
        .ready     (ready),
        .done      (done),
        .bcd       (bcd),
        .turn_on   (turn_on),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef SCORE_BLANK_EN
    localparam logic [7:0] ON_AT_RESET = 8'h01;
`else
    localparam logic [7:0] ON_AT_RESET = 8'hFF;
`endif

    // reference model: decimal digits by plain division
    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_on(input int unsigned v);
`ifdef SCORE_BLANK_EN
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return 8'((1 << n) - 1);
`else
        return 8'hFF;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    // Full conversion; optionally pokes a second start at cycle poke_k after acceptance.
    task automatic run_conv(input logic [15:0] val, input int poke_k, input logic [15:0] poke_val);
        logic [31:0] prev_bcd;
        logic [7:0]  prev_on;
        int          lat;
        bit          held;
        prev_bcd = bcd;
        prev_on  = turn_on;
        check("ready_before_start", ready, 1);
        start  = 1'b1;
        bin_in = val;
        @(negedge clock);
        start  = 1'b0;
        bin_in = 16'($urandom);
        lat  = 0;
        held = 1;
        for (int k = 1; k <= 40; k++) begin
            if (k == poke_k) begin
                start  = 1'b1;
                bin_in = poke_val;
            end
            @(negedge clock);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (ready || bcd !== prev_bcd || turn_on !== prev_on) held = 0;
        end
        check("latency", lat, 17);
        check("held_during_conv", held, 1);
        check("ready_in_done", ready, 0);
        check("bcd", bcd, ref_bcd(val));
        check("turn_on", turn_on, ref_on(val));
        @(negedge clock);
        check("done_pulse_width", done, 0);
        check("ready_after_done", ready, 1);
        check("bcd_kept", bcd, ref_bcd(val));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_L  = 1'b1;
        start    = 1'b0;
        bin_in   = '0;
        @(negedge clock);

        do_reset();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_turn_on", turn_on, ON_AT_RESET);
        check("rst_state", dbg_state, IDLE);

        run_conv(16'd1234, 0, 16'd0);
        run_conv(16'd65535, 0, 16'd0);
        run_conv(16'd0, 0, 16'd0);

        // second start three cycles in must be dropped
        run_conv(16'd1234, 3, 16'd9999);
        watch_no_done("no_extra_done", 20);

        // abort mid-conversion with reset
        start  = 1'b1;
        bin_in = 16'd4321;
        @(negedge clock);
        start  = 1'b0;
        repeat (4) @(negedge clock);
        reset_L = 1'b0;
        @(negedge clock);
        reset_L = 1'b1;
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
        check("abort_bcd", bcd, 0);
        check("abort_turn_on", turn_on, ON_AT_RESET);
        watch_no_done("abort_no_done", 20);
        run_conv(16'd4321, 0, 16'd0);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] v;
            case (i % 4)
                0: v = 16'($urandom_range(0, 9));
                1: v = 16'($urandom_range(10, 999));
                default: v = 16'($urandom_range(0, 65535));
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_conv(v, (i % 5 == 0) ? int'($urandom_range(1, 17)) : 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
